// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states, Booth ops and decode helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        B_NOP = 2'd0,
        B_ADD = 2'd1,
        B_SUB = 2'd2
    } booth_op_e;

    localparam int unsigned BOOTH_PAIR_W = 2;

    // Radix-2 Booth recoding of {multiplier LSB, previously shifted-out bit}.
    function automatic booth_op_e booth_op(input logic [BOOTH_PAIR_W-1:0] pair);
        case (pair)
            2'b01:   return B_ADD;
            2'b10:   return B_SUB;
            default: return B_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_decode.sv
// Combinational Booth decode: picks the shared adder's B operand and carry-in from the Booth pair.
module booth_decode
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    en,
    input  logic [BOOTH_PAIR_W-1:0] pair,
    input  logic [WIDTH-1:0]        m,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin
);

    booth_op_e op;

    // Subtract is A + ~M + 1 so one adder serves both directions.
    always_comb begin
        op      = en ? booth_op(pair) : B_NOP;
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            B_ADD: add_b = m;
            B_SUB: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_booth_seq.sv
// Radix-2 Booth signed multiplier sequencer driving an external shared CLA, one Booth step per cycle.
// Optional overflow exception enabled by defining MULT_EXCEPTION_EN.
module mult_booth_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_ovf,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, h_q, l_q;
    logic             q_m1_q;
    logic [CNT_W-1:0] cnt_q;

    logic             run_c, last_c, sign_c;
    logic [WIDTH-1:0] h_nxt_c, l_nxt_c;

    // Next-state logic; a start pulse in any state (re)starts the operation.
    always_comb begin
        state_d = state_q;
        run_c   = (state_q == RUN);
        last_c  = run_c && !ctrl_MULT && (cnt_q == CNT_W'(WIDTH - 1));
        case (state_q)
            IDLE: if (ctrl_MULT) state_d = RUN;
            RUN: begin
                if (ctrl_MULT)   state_d = RUN;
                else if (last_c) state_d = DONE;
            end
            DONE:    state_d = ctrl_MULT ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    booth_decode #(.WIDTH(WIDTH)) u_decode (
        .en      (run_c),
        .pair    ({l_q[0], q_m1_q}),
        .m       (m_q),
        .add_b   (add_b),
        .add_cin (add_cin)
    );

    assign add_a = h_q;

    // Arithmetic right shift of {H, L}; the true sign survives adder overflow.
    always_comb begin
        sign_c  = add_sum[WIDTH-1] ^ add_ovf;
        h_nxt_c = {sign_c, add_sum[WIDTH-1:1]};
        l_nxt_c = {add_sum[0], l_q[WIDTH-1:1]};
    end

`ifdef MULT_EXCEPTION_EN
    logic exc_c;
    assign exc_c = (h_nxt_c != {WIDTH{l_nxt_c[WIDTH-1]}});
`else
    assign data_exception = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q            <= '0;
            h_q            <= '0;
            l_q            <= '0;
            q_m1_q         <= 1'b0;
            cnt_q          <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
`ifdef MULT_EXCEPTION_EN
            data_exception <= 1'b0;
`endif
        end else begin
            busy           <= (state_d == RUN);
            data_resultRDY <= (state_d == DONE);
            if (ctrl_MULT) begin
                m_q    <= data_operandA;
                h_q    <= '0;
                l_q    <= data_operandB;
                q_m1_q <= 1'b0;
                cnt_q  <= '0;
            end else if (run_c) begin
                h_q    <= h_nxt_c;
                l_q    <= l_nxt_c;
                q_m1_q <= l_q[0];
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            // Result captured on the final commit so it is valid during DONE.
            if (last_c) begin
                data_result <= l_nxt_c;
`ifdef MULT_EXCEPTION_EN
                data_exception <= exc_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq with a behavioural shared adder and an expected-result queue.
module tb_mult_booth_seq;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         exc;
    } exp_t;

    logic         clock;
    logic         reset_n;
    logic         ctrl_MULT;
    logic [W-1:0] data_operandA, data_operandB;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_ovf;
    logic [W-1:0] data_result;
    logic         data_resultRDY, data_exception, busy;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    mult_booth_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_cin        (add_cin),
        .add_sum        (add_sum),
        .add_ovf        (add_ovf),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    // Stand-in for the parent's shared adder.
    assign add_sum = add_a + add_b + W'(add_cin);
    assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        exp_t e;
        p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        e.res = p[W-1:0];
`ifdef MULT_EXCEPTION_EN
        e.exc = (p != {{W{p[W-1]}}, p[W-1:0]});
`else
        e.exc = 1'b0;
`endif
        return e;
    endfunction

    // Called at a falling edge; the start is sampled on the next rising edge (cycle 0).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(model(a, b));
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    // Observes only: returns cycle of RDY relative to the start edge (-1 on timeout).
    task automatic wait_rdy(output int lat, output int busy_n, output logic busy_at_rdy,
                            output logic [W-1:0] res, output logic exc);
        lat = -1; busy_n = 0; busy_at_rdy = 1'b0; res = '0; exc = 1'b0;
        for (int c = 1; c <= int'(W) + 20; c++) begin
            if (data_resultRDY) begin
                lat = c; res = data_result; exc = data_exception; busy_at_rdy = busy;
                break;
            end
            if (busy) busy_n++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({data_result, data_resultRDY, data_exception, busy, add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: res=%h rdy=%b exc=%b busy=%b a=%h b=%h cin=%b, need all 0",
                     data_result, data_resultRDY, data_exception, busy, add_a, add_b, add_cin);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({data_resultRDY, busy, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b b=%h cin=%b, need 0", data_resultRDY, busy, add_b, add_cin);
        end
    endtask

    task automatic test_products();
        logic [W-1:0] as [10];
        logic [W-1:0] bs [10];
        int lat, bn;
        logic br, exc;
        logic [W-1:0] res;
        exp_t e;
        as[0] = 32'd3;          bs[0] = 32'd5;
        as[1] = 32'hFFFF_FFF9;  bs[1] = 32'd6;
        as[2] = 32'h8000_0000;  bs[2] = 32'hFFFF_FFFF;
        as[3] = 32'd65536;      bs[3] = 32'd65536;
        as[4] = 32'h7FFF_FFFF;  bs[4] = 32'h7FFF_FFFF;
        as[5] = 32'hFFFF_8000;  bs[5] = 32'h0000_FFFF;
        for (int i = 6; i < 10; i++) begin
            as[i] = $urandom;
            bs[i] = (i % 2 == 0) ? $urandom : W'($urandom_range(0, 1000)) - W'(500);
        end
        for (int i = 0; i < 10; i++) begin
            start_op(as[i], bs[i]);
            wait_rdy(lat, bn, br, res, exc);
            e = exp_q.pop_front();
            checks++;
            if (lat != int'(W) + 1) begin
                errors++; $display("FAIL latency[%0d]: got %0d need %0d", i, lat, W + 1);
            end
            checks++;
            if (res !== e.res) begin
                errors++; $display("FAIL result[%0d] %h*%h: got %h need %h", i, as[i], bs[i], res, e.res);
            end
            checks++;
            if (exc !== e.exc) begin
                errors++; $display("FAIL exception[%0d] %h*%h: got %b need %b", i, as[i], bs[i], exc, e.exc);
            end
            if (i == 0) begin
                checks++;
                if (bn != int'(W) || br !== 1'b0) begin
                    errors++; $display("FAIL busy_window: busy cycles %0d need %0d, busy at rdy %b need 0", bn, W, br);
                end
            end
            @(negedge clock);
            checks++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== e.res) begin
                errors++;
                $display("FAIL after_done[%0d]: rdy=%b busy=%b res=%h, need 0 0 %h", i, data_resultRDY, busy, data_result, e.res);
            end
        end
    endtask

    task automatic test_abort();
        int lat, bn, early;
        logic br, exc;
        logic [W-1:0] res;
        exp_t e;
        early = 0;
        start_op(32'd3, 32'd5);
        repeat (8) begin
            if (data_resultRDY) early++;
            @(negedge clock);
        end
        void'(exp_q.pop_back());
        start_op(32'd4, 32'd4);
        wait_rdy(lat, bn, br, res, exc);
        e = exp_q.pop_front();
        checks++;
        if (early != 0 || lat != int'(W) + 1) begin
            errors++; $display("FAIL abort_timing: early rdy %0d, latency from restart %0d need %0d", early, lat, W + 1);
        end
        checks++;
        if (res !== e.res || res !== 32'd16) begin
            errors++; $display("FAIL abort_result: got %h need %h", res, e.res);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        logic br, exc;
        logic [W-1:0] res;
        exp_t e;
        start_op(32'hFFFF_FFFE, 32'd21);
        wait_rdy(lat, bn, br, res, exc);
        e = exp_q.pop_front();
        checks++;
        if (lat != int'(W) + 1 || res !== e.res) begin
            errors++; $display("FAIL b2b_first: lat %0d res %h, need %0d %h", lat, res, W + 1, e.res);
        end
        start_op(32'd1234, 32'hFFFF_FC00);
        wait_rdy(lat, bn, br, res, exc);
        e = exp_q.pop_front();
        checks++;
        if (lat != int'(W) + 1 || res !== e.res || exc !== e.exc) begin
            errors++; $display("FAIL b2b_second: lat %0d res %h exc %b, need %0d %h %b", lat, res, exc, W + 1, e.res, e.exc);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midrun();
        int lat, bn;
        logic br, exc;
        logic [W-1:0] res;
        exp_t e;
        start_op(32'd3, 32'd5);
        repeat (10) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midrun_busy: got %b need 1", busy);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({data_result, data_resultRDY, data_exception, busy, add_a, add_b, add_cin} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: res=%h rdy=%b exc=%b busy=%b a=%h b=%h cin=%b, need all 0",
                     data_result, data_resultRDY, data_exception, busy, add_a, add_b, add_cin);
        end
        void'(exp_q.pop_front());
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_op(32'd2, 32'd2);
        wait_rdy(lat, bn, br, res, exc);
        e = exp_q.pop_front();
        checks++;
        if (lat != int'(W) + 1 || res !== e.res || res !== 32'd4) begin
            errors++; $display("FAIL after_reset_op: lat %0d res %h, need %0d %h", lat, res, W + 1, e.res);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_products();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
